vector_vector_alu: RTL and testbench

- Stage directly downstream of filterReduceUnit. Consumes its per-chain N-lane reduced vectors.
- Applies an element-wise operation against a per-chain accumulator: pass, add, signed max or signed min.
- Optionally caches the result back into the accumulator.
- Optionally emits only at end of frame, so a frame's vectors collapse into one result per chain.
- Feeds the downstream packing/trace-buffer stage.

---
 rtl/vector_vector_alu_if.sv | 33 +++
 rtl/vector_vector_alu.sv | 117 +++++++++++
 tb/tb_vector_vector_alu.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_vector_alu_if.sv
// Stream and configuration bundle for vector_vector_alu.
// The master drives inputs and configuration; the slave returns results.
interface vector_vector_alu_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  localparam int CW = $clog2(MAX_CHAINS);

  logic                         tracing;
  logic                         valid_in;
  logic                         eof_in;
  logic [CW-1:0]                chainId_in;
  logic [7:0]                   configId;
  logic [7:0]                   configData;
  logic [N-1:0][DATA_WIDTH-1:0] vector_in;
  logic [N-1:0][DATA_WIDTH-1:0] vector_out;
  logic [CW-1:0]                chainId_out;
  logic                         valid_out;
  logic                         eof_out;

  modport master (
    output tracing, valid_in, eof_in, chainId_in,
    output configId, configData, vector_in,
    input  vector_out, chainId_out, valid_out, eof_out
  );

  modport slave (
    input  tracing, valid_in, eof_in, chainId_in,
    input  configId, configData, vector_in,
    output vector_out, chainId_out, valid_out, eof_out
  );
endinterface

// File: rtl/vector_vector_alu.sv
// Element-wise vector ALU against per-chain accumulators.
// Optional caching and end-of-frame-only emission collapse frames.
module vector_vector_alu #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd1,
  parameter logic [2*MAX_CHAINS-1:0] INITIAL_FIRMWARE_OP = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_FLAGS = '0
) (
  input  logic             clk,
  input  logic             reset,
  vector_vector_alu_if.slave bus
);
  localparam int CW = $clog2(MAX_CHAINS);
  localparam int PW = CW + 1;

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_ADD  = 2'd1,
    OP_MAX  = 2'd2,
    OP_MIN  = 2'd3
  } op_e;

  op_e                   op    [MAX_CHAINS];
  logic [1:0]            flags [MAX_CHAINS];
  vec_t                  acc   [MAX_CHAINS];
  logic [MAX_CHAINS-1:0] first;
  logic [PW-1:0]         cfg_ptr;

  logic          accept;
  logic          emit;
  logic          cfg_hit;
  logic [CW-1:0] ch;
  logic [CW-1:0] cfg_ch;
  op_e           op_c;
  logic          cache_c;
  logic          eof_only_c;
  vec_t          res;
  logic          cfg_unused;

  assign ch         = bus.chainId_in;
  assign op_c       = op[ch];
  assign cache_c    = flags[ch][0];
  assign eof_only_c = flags[ch][1];
  assign accept     = bus.tracing && bus.valid_in;
  assign emit       = accept && (!eof_only_c || bus.eof_in);
  assign cfg_hit    = bus.configId == PERSONAL_CONFIG_ID;
  assign cfg_ch     = cfg_ptr[PW-1:1];
  assign cfg_unused = ^bus.configData[7:2];

  // First vector of a frame passes straight through for every op.
  always_comb begin
    res = bus.vector_in;
    if (!first[ch]) begin
      for (int i = 0; i < N; i++) begin
        unique case (op_c)
          OP_PASS: res[i] = bus.vector_in[i];
          OP_ADD:  res[i] = acc[ch][i] + bus.vector_in[i];
          OP_MAX: begin
            if ($signed(acc[ch][i]) > $signed(bus.vector_in[i]))
              res[i] = acc[ch][i];
          end
          OP_MIN: begin
            if ($signed(acc[ch][i]) < $signed(bus.vector_in[i]))
              res[i] = acc[ch][i];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid_out   <= 1'b0;
      bus.eof_out     <= 1'b0;
      bus.chainId_out <= '0;
      bus.vector_out  <= '0;
      first           <= '1;
      cfg_ptr         <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        acc[c]   <= '0;
        op[c]    <= op_e'(INITIAL_FIRMWARE_OP[2*c +: 2]);
        flags[c] <= INITIAL_FIRMWARE_FLAGS[8*c +: 2];
      end
    end else begin
      if (cfg_hit) begin
        if (cfg_ptr[0])
          flags[cfg_ch] <= bus.configData[1:0];
        else
          op[cfg_ch] <= op_e'(bus.configData[1:0]);
        cfg_ptr <= cfg_ptr + PW'(1);
      end else begin
        cfg_ptr <= '0;
      end

      bus.valid_out <= emit;
      if (emit) begin
        bus.vector_out  <= res;
        bus.chainId_out <= ch;
        bus.eof_out     <= bus.eof_in;
      end

      // End of frame wins over caching so the next frame starts clean.
      if (accept) begin
        if (bus.eof_in) begin
          acc[ch]   <= '0;
          first[ch] <= 1'b1;
        end else if (cache_c) begin
          acc[ch]   <= res;
          first[ch] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_vector_vector_alu.sv
// Bench for vector_vector_alu: directed frames plus random traffic
// checked cycle by cycle against a behavioural model.
module tb_vector_vector_alu;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int MC = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  vector_vector_alu_if #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)) bus ();

  vector_vector_alu #(
    .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_acc [MC][N];
  bit          m_first [MC];
  int          m_op [MC];
  int          m_fl [MC];
  int          m_ptr;
  bit          e_valid;
  logic [31:0] e_vec [N];
  int          e_ch;
  bit          e_eof;
  logic [31:0] log_v [$];
  int          log_c [$];
  bit          log_e [$];

  int fw_op [MC];
  int fw_fl [MC];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < MC; c++) begin
        for (int i = 0; i < N; i++) m_acc[c][i] = 0;
        m_first[c] = 1;
        m_op[c] = 0;
        m_fl[c] = 0;
      end
      m_ptr = 0;
      e_valid = 0;
      e_ch = 0;
      e_eof = 0;
      for (int i = 0; i < N; i++) e_vec[i] = 0;
    end else begin
      e_valid = 0;
      if (bus.tracing && bus.valid_in) begin
        int c;
        logic [31:0] r [N];
        c = int'(bus.chainId_in);
        for (int i = 0; i < N; i++) begin
          logic [31:0] a, x;
          a = m_acc[c][i];
          x = bus.vector_in[i];
          if (m_first[c] || m_op[c] == 0) r[i] = x;
          else if (m_op[c] == 1) r[i] = a + x;
          else if (m_op[c] == 2) r[i] = (int'(a) > int'(x)) ? a : x;
          else r[i] = (int'(a) < int'(x)) ? a : x;
        end
        if (m_fl[c] % 2 == 1) begin
          m_acc[c] = r;
          m_first[c] = 0;
        end
        if (bus.eof_in) begin
          for (int i = 0; i < N; i++) m_acc[c][i] = 0;
          m_first[c] = 1;
        end
        if (m_fl[c] / 2 == 0 || bus.eof_in) begin
          e_valid = 1;
          e_vec = r;
          e_ch = c;
          e_eof = bus.eof_in;
          log_v.push_back(r[0]);
          log_c.push_back(c);
          log_e.push_back(bus.eof_in);
        end
      end
      if (bus.configId == 8'd1) begin
        if (m_ptr % 2 == 1) m_fl[m_ptr / 2] = int'(bus.configData[1:0]);
        else m_op[m_ptr / 2] = int'(bus.configData[1:0]);
        m_ptr = (m_ptr + 1) % (2 * MC);
      end else begin
        m_ptr = 0;
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_out", 64'(bus.valid_out), 64'(e_valid));
      if (e_valid) begin
        chk("chainId_out", 64'(bus.chainId_out), 64'(e_ch));
        chk("eof_out", 64'(bus.eof_out), 64'(e_eof));
        for (int i = 0; i < N; i++)
          chk($sformatf("lane%0d", i), 64'(bus.vector_out[i]), 64'(e_vec[i]));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.tracing = 1;
    bus.valid_in = 0;
    bus.eof_in = 0;
    bus.configId = 0;
    cyc();
  endtask

  task automatic send(int ch, logic [31:0] v, bit eof, bit tr = 1);
    bus.tracing = tr;
    bus.valid_in = 1;
    bus.eof_in = eof;
    bus.chainId_in = 2'(ch);
    bus.vector_in = {N{v}};
    bus.configId = 0;
    cyc();
  endtask

  task automatic program_fw();
    bus.valid_in = 0;
    for (int s = 0; s < 2 * MC; s++) begin
      bus.configId = 8'd1;
      bus.configData = 8'((s % 2 == 1) ? fw_fl[s/2] : fw_op[s/2]);
      bus.configData[7:2] = 6'($urandom);
      cyc();
    end
    bus.configId = 0;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1;
    bus.valid_in = 0;
    bus.configId = 0;
    for (int c = 0; c < MC; c++) begin
      fw_op[c] = 0;
      fw_fl[c] = 0;
    end
    cyc();
    reset = 0;
  endtask

  task automatic entry(string nm, int idx, logic [31:0] v, int c, bit e);
    if (idx >= log_v.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: got no result, expected value %0h", nm, v);
    end else begin
      chk({nm, "_val"}, 64'(log_v[idx]), 64'(v));
      chk({nm, "_ch"}, 64'(log_c[idx]), 64'(c));
      chk({nm, "_eof"}, 64'(log_e[idx]), 64'(e));
    end
  endtask

  task automatic clr();
    log_v.delete();
    log_c.delete();
    log_e.delete();
  endtask

  initial begin
    reset = 1;
    bus.tracing = 0;
    bus.valid_in = 0;
    bus.eof_in = 0;
    bus.chainId_in = 0;
    bus.configId = 0;
    bus.configData = 0;
    bus.vector_in = '0;
    do_reset();
    reset = 1;
    cyc();
    reset = 0;
    chk_en = 1;
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_vec", 64'(|bus.vector_out), 64'd0);
    chk("rst_ch", 64'(bus.chainId_out), 64'd0);
    chk("rst_eof", 64'(bus.eof_out), 64'd0);

    clr();
    send(0, 32'd5, 0);
    send(0, -32'sd3, 0);
    idle();
    chk("pass_cnt", 64'(log_v.size()), 64'd2);
    entry("pass0", 0, 32'd5, 0, 0);
    entry("pass1", 1, 32'hFFFF_FFFD, 0, 0);

    fw_op[1] = 1; fw_fl[1] = 3;
    program_fw();
    clr();
    send(1, 32'd10, 0);
    send(1, 32'd20, 0);
    send(1, 32'd30, 1);
    send(1, 32'd7, 1);
    idle();
    chk("add_cnt", 64'(log_v.size()), 64'd2);
    entry("add_sum", 0, 32'd60, 1, 1);
    entry("add_fresh", 1, 32'd7, 1, 1);

    fw_op[2] = 2; fw_fl[2] = 3;
    program_fw();
    clr();
    send(2, -32'sd8, 0);
    send(2, -32'sd2, 0);
    send(2, -32'sd5, 1);
    fw_op[2] = 3;
    program_fw();
    send(2, -32'sd8, 0);
    send(2, -32'sd2, 0);
    send(2, -32'sd5, 1);
    idle();
    chk("mm_cnt", 64'(log_v.size()), 64'd2);
    entry("max", 0, 32'hFFFF_FFFE, 2, 1);
    entry("min", 1, 32'hFFFF_FFF8, 2, 1);

    fw_op[0] = 1; fw_fl[0] = 1;
    program_fw();
    clr();
    send(0, 32'h7FFF_FFFF, 0);
    send(0, 32'd2, 1);
    idle();
    entry("wrap0", 0, 32'h7FFF_FFFF, 0, 0);
    entry("wrap1", 1, 32'h8000_0001, 0, 1);

    fw_op[3] = 1; fw_fl[3] = 3;
    program_fw();
    clr();
    send(1, 32'd1, 0);
    send(3, 32'd100, 0);
    send(1, 32'd1, 0);
    send(3, 32'd100, 0);
    send(1, 32'd1, 1);
    send(3, 32'd100, 1);
    send(1, 32'd1, 0);
    send(3, 32'd100, 0);
    send(1, 32'd1, 0, 0);
    send(3, 32'd100, 0);
    send(1, 32'd1, 1);
    send(3, 32'd100, 1);
    idle();
    chk("il_cnt", 64'(log_v.size()), 64'd4);
    entry("il_c1", 0, 32'd3, 1, 1);
    entry("il_c3", 1, 32'd300, 3, 1);
    entry("drop_c1", 2, 32'd2, 1, 1);
    entry("drop_c3", 3, 32'd300, 3, 1);

    clr();
    send(0, 32'd4, 0);
    send(0, 32'd4, 0);
    do_reset();
    send(0, 32'd9, 1);
    send(1, 32'd5, 0);
    idle();
    entry("rst_mid", 2, 32'd9, 0, 1);
    entry("rst_fw", 3, 32'd5, 1, 0);

    fw_op[0] = 1; fw_fl[0] = 1;
    program_fw();
    clr();
    send(0, 32'd10, 0);
    bus.configId = 8'd1;
    bus.configData = 8'd3;
    bus.valid_in = 1;
    bus.vector_in = {N{32'd5}};
    cyc();
    bus.configId = 8'd1;
    bus.configData = 8'd1;
    bus.vector_in = {N{32'd4}};
    cyc();
    idle();
    entry("cfg_pre", 0, 32'd10, 0, 0);
    entry("cfg_old", 1, 32'd15, 0, 0);
    entry("cfg_new", 2, 32'd4, 0, 0);

    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < MC; c++) begin
        fw_op[c] = int'($urandom_range(0, 3));
        fw_fl[c] = int'($urandom_range(0, 3));
      end
      program_fw();
      for (int k = 0; k < 300; k++) begin
        int n;
        bus.tracing = ($urandom_range(0, 9) != 0);
        bus.valid_in = ($urandom_range(0, 3) != 0);
        bus.eof_in = ($urandom_range(0, 4) == 0);
        bus.chainId_in = 2'($urandom_range(0, MC - 1));
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 3) == 0) bus.vector_in[i] = $urandom;
          else bus.vector_in[i] = 32'($urandom_range(0, 40)) - 32'd20;
        end
        n = int'($urandom_range(0, 19));
        bus.configId = (n == 0) ? 8'd1 : (n == 1) ? 8'($urandom) : 8'd0;
        bus.configData = 8'($urandom);
        reset = ($urandom_range(0, 199) == 0);
        cyc();
      end
      reset = 0;
      idle();
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
